// File: rtl/ext_bus_arbiter.sv
// Two-requester round-robin arbiter that serialises 32-bit transactions onto the
// 8-bit multiplexed external bus as 4 address beats, 1 control beat and 4 data beats.
module ext_bus_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_dout,
    output logic [7:0]  bus_oe,
    input  logic [7:0]  bus_din,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_CTRL = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state;
    logic [1:0]  beat;
    logic [1:0]  nbeat;
    logic [3:0]  wcnt;
    logic        last_grant;
    logic        we_q;
    logic        id_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] rdata_q;

    logic        gnt;
    logic        gnt_vld;
    logic        hs;
    logic [31:0] addr_sel;
    logic [31:0] wdata_sel;
    logic        we_sel;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        logic [31:0] sh;
        sh = w >> {k, 3'b000};
        return sh[7:0];
    endfunction

    // Round-robin choice; only offered while idle and out of reset.
    always_comb begin
        gnt_vld = |req_valid;
        if (req_valid == 2'b11) gnt = ~last_grant;
        else                    gnt = req_valid[1];
        req_ready = 2'b00;
        if (rst_n && state == S_IDLE && gnt_vld)
            req_ready = gnt ? 2'b10 : 2'b01;
    end

    assign hs        = |(req_valid & req_ready);
    assign addr_sel  = gnt ? req_addr[63:32]  : req_addr[31:0];
    assign wdata_sel = gnt ? req_wdata[63:32] : req_wdata[31:0];
    assign we_sel    = req_we[gnt];
    assign nbeat     = beat + 2'd1;
    assign busy      = (state != S_IDLE);

    // Bus lanes are registered: each transition loads the values for the next beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beat       <= 2'd0;
            wcnt       <= 4'd0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            id_q       <= 1'b0;
            bus_addr   <= 8'h00;
            bus_dout   <= 8'h00;
            bus_oe     <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            bus_addr  <= 8'h00;
            bus_dout  <= 8'h00;
            bus_oe    <= 8'h00;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        state      <= S_ADDR;
                        beat       <= 2'd0;
                        we_q       <= we_sel;
                        id_q       <= gnt;
                        last_grant <= gnt;
                        bus_addr   <= addr_sel[7:0];
                        if (we_sel) begin
                            bus_dout <= wdata_sel[7:0];
                            bus_oe   <= 8'hFF;
                        end
                    end
                end
                S_ADDR: begin
                    beat <= nbeat;
                    if (beat == 2'd3) begin
                        state    <= S_CTRL;
                        bus_addr <= {6'b0, 1'b1, we_q};
                    end else begin
                        bus_addr <= byte_of(addr_q, nbeat);
                        if (we_q) begin
                            bus_dout <= byte_of(wdata_q, nbeat);
                            bus_oe   <= 8'hFF;
                        end
                    end
                end
                S_CTRL: begin
                    beat <= 2'd0;
                    wcnt <= 4'd0;
                    state <= (WAIT_CYCLES == 0) ? S_DATA : S_WAIT;
                end
                S_WAIT: begin
                    wcnt <= wcnt + 4'd1;
                    if (wcnt == WAIT_LAST) state <= S_DATA;
                end
                S_DATA: begin
                    beat <= nbeat;
                    if (beat == 2'd3) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_rdata <= we_q ? 32'h0 : {bus_din, rdata_q};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload and read-assembly registers need no reset: they are reloaded per transaction.
    always_ff @(posedge clk) begin
        if (hs) begin
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
        end
        if (state == S_DATA && !we_q) begin
            case (beat)
                2'd0:    rdata_q[7:0]   <= bus_din;
                2'd1:    rdata_q[15:8]  <= bus_din;
                2'd2:    rdata_q[23:16] <= bus_din;
                default: ;
            endcase
        end
    end

endmodule
